seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Upstream stage of the seven-segment decode path. Accepts a packed multi-digit hex value, encodes each nibble into a 7-bit segment pattern, and time-multiplexes the digits onto one shared segment bus with a rotating one-hot digit select. Its segment patterns are exactly the ones the downstream segment-to-value decoder consumes.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal range 1..8).
REFRESH_DIV, 1000, clock cycles each digit is shown (legal range >= 2).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
value  input  4*NUM_DIGITS  packed hex digits; digit 0 = value[3:0] (rightmost).
load  input  1  one-cycle strobe; captures value as a pending update.
enable  input  1  1 = scanning; 0 = blank outputs and freeze counters.
lz_en  input  1  1 = suppress leading zeros.
display  output  7  segment pattern, bit6..bit0 = a,b,c,d,e,f,g, active-high.
digit_sel  output  NUM_DIGITS  one-hot active-high digit enable.
frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high on reset; all state clears immediately on assertion.
- Reset values: display=7'b0000000, digit_sel=0, frame_done=0, prescaler=0, digit index=0, active register=0, pending register=0, pending flag=0.
- Encoding, nibble to pattern: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Prescaler: counts 0..REFRESH_DIV-1 while enable=1.
  - A tick is prescaler == REFRESH_DIV-1.
  - On a tick, the prescaler returns to 0 and the digit index advances; it wraps from NUM_DIGITS-1 to 0.
- Outputs are registered and reflect the current digit index and active register with 1-cycle latency:
  - digit_sel = 1<<idx.
  - display = encode(active[4*idx+3:4*idx]), or 0 if that digit is suppressed.
- Leading-zero suppression (lz_en=1): digit i is blanked (display=0, digit_sel still asserted) if i>0 and all active nibbles i..NUM_DIGITS-1 are 0. Digit 0 is never suppressed.
- Frame boundary: a tick while idx == NUM_DIGITS-1.
  - frame_done pulses high for the following cycle.
  - If the pending flag is set, the active register takes the pending register and the pending flag clears.
- Load:
  - Captures value into the pending register and sets the pending flag.
  - A later load before the boundary overwrites pending; the last load wins.
  - Load coincident with a frame boundary writes value directly to the active register and leaves the pending flag clear.
  - The active register never changes mid-frame, so there is no tearing.
- Load is accepted regardless of enable.
- enable=0:
  - Next cycle: display=0, digit_sel=0, frame_done=0.
  - Prescaler and idx hold.
  - When enable returns to 1, scanning resumes from the held idx and prescaler.
- Reset mid-frame: immediate return to reset values. The pending update is discarded.
- NUM_DIGITS=1: every tick is a frame boundary. digit_sel is constantly 1 after the first cycle.

Test Plan:
- Reset and first frame (NUM_DIGITS=4, REFRESH_DIV=4, enable=1, no load).
  - Assert then release reset -> display=0000000 and digit_sel=0000 during reset.
  - Then display=1111110 with digit_sel 0001, 0010, 0100, 1000, each held 4 cycles.
  - frame_done pulses once every 16 cycles.
- Full code sweep (NUM_DIGITS=1, REFRESH_DIV=2).
  - Load each of 0..F at successive frame boundaries -> display cycles 1111110 … 1000111, matching the encoding list exactly.
- Tear-free update.
  - Load 16'h1234 mid-frame, then 16'hABCD before the boundary -> the current frame still shows the old value.
  - The next frame shows A,b,C,d: digit0=0111101, digit3=1110111. The value 1234 is never displayed.
- Leading-zero suppression (lz_en=1, value=16'h0050).
  - Digits 3 and 2 show display=0000000 with their digit_sel asserted; digit1=1011011, digit0=1111110.
  - value=16'h0000 -> only digit0 lit, showing 1111110.
- Enable gating.
  - Drop enable for 10 cycles mid-slot on digit 2 -> display=0 and digit_sel=0 throughout.
  - On re-enable, digit 2 resumes with its remaining slot cycles.
- Async reset mid-operation with a pending load.
  - Pending 16'hFFFF, assert reset between clock edges -> outputs 0 immediately, without waiting for a clock edge.
  - After release, all digits show 1111110.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: encodes a packed hex value and scans it one digit at a time onto a shared segment bus.
// Updates are staged in a pending register and only land at frame boundaries, so a frame never tears.
module seg7_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic                    enable,
   input  logic                    lz_en,
   output logic [6:0]              display,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = $clog2(REFRESH_DIV);
   logic [PW-1:0]           r_pre;
   logic [IW-1:0]           r_idx;
   logic [4*NUM_DIGITS-1:0] r_active;
   logic [4*NUM_DIGITS-1:0] r_pending;
   logic                    r_pend_flag;
   logic                    w_tick;
   logic                    w_frame;
   logic [3:0]              w_nib;
   logic [6:0]              w_seg;
   logic [NUM_DIGITS:0]     w_zf;
   logic [NUM_DIGITS-1:0]   w_sup;

   function automatic logic [6:0] encode(input logic [3:0] n);
      case (n)
         4'h0: encode = 7'b1111110;
         4'h1: encode = 7'b0110000;
         4'h2: encode = 7'b1101101;
         4'h3: encode = 7'b1111001;
         4'h4: encode = 7'b0110011;
         4'h5: encode = 7'b1011011;
         4'h6: encode = 7'b1011111;
         4'h7: encode = 7'b1110000;
         4'h8: encode = 7'b1111111;
         4'h9: encode = 7'b1110011;
         4'hA: encode = 7'b1110111;
         4'hB: encode = 7'b0011111;
         4'hC: encode = 7'b1001110;
         4'hD: encode = 7'b0111101;
         4'hE: encode = 7'b1001111;
         default: encode = 7'b1000111;
      endcase
   endfunction

   assign w_tick  = enable && r_pre == PW'(REFRESH_DIV - 1);
   assign w_frame = w_tick && r_idx == IW'(NUM_DIGITS - 1);

   // w_zf[i]: nibbles i..top of the active value are all zero
   assign w_zf[NUM_DIGITS] = 1'b1;
   generate
      for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
         assign w_zf[g]  = w_zf[g+1] && r_active[4*g +: 4] == 4'h0;
         assign w_sup[g] = (g > 0) && w_zf[g];
      end
   endgenerate

   assign w_nib = r_active[4*r_idx +: 4];
   assign w_seg = lz_en && w_sup[r_idx] ? 7'b0 : encode(w_nib);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre       <= '0;
         r_idx       <= '0;
         r_active    <= '0;
         r_pending   <= '0;
         r_pend_flag <= 1'b0;
         display     <= '0;
         digit_sel   <= '0;
         frame_done  <= 1'b0;
      end else begin
         if (w_tick) begin
            r_pre <= '0;
            r_idx <= w_frame ? '0 : r_idx + 1'b1;
         end else if (enable) begin
            r_pre <= r_pre + 1'b1;
         end
         // a load on the boundary itself is the newest data and bypasses pending
         if (w_frame) begin
            r_active    <= load ? value : r_pend_flag ? r_pending : r_active;
            r_pend_flag <= 1'b0;
         end else if (load) begin
            r_pending   <= value;
            r_pend_flag <= 1'b1;
         end
         display    <= enable ? w_seg : '0;
         digit_sel  <= enable ? NUM_DIGITS'(1) << r_idx : '0;
         frame_done <= w_frame;
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scenarios on a 4-digit/div-4 instance and a 1-digit/div-2 instance.
module tb_seg7_scan_driver;
   logic        clk = 1'b0;
   logic        rst4, load4, en4, lz4;
   logic [15:0] val4;
   logic [6:0]  disp4;
   logic [3:0]  sel4;
   logic        fd4;
   logic        rst1, load1, en1, lz1;
   logic [3:0]  val1;
   logic [6:0]  disp1;
   logic [0:0]  sel1;
   logic        fd1;
   int          total = 0;
   int          bad = 0;
   logic [6:0]  enc_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u4 (
      .clk(clk), .reset(rst4), .value(val4), .load(load4), .enable(en4), .lz_en(lz4),
      .display(disp4), .digit_sel(sel4), .frame_done(fd4));

   seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(2)) u1 (
      .clk(clk), .reset(rst1), .value(val1), .load(load1), .enable(en1), .lz_en(lz1),
      .display(disp1), .digit_sel(sel1), .frame_done(fd1));

   task automatic test_reset;
      logic [3:0] es;
      rst4 = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (disp4 !== 7'b0 || sel4 !== 4'b0 || fd4 !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: display=%b sel=%b fd=%b required all 0", disp4, sel4, fd4);
      end
      rst4 = 1'b0;
      for (int r = 0; r < 32; r++) begin
         @(negedge clk);
         es = 4'b1 << ((r / 4) % 4);
         total++;
         if (sel4 !== es || disp4 !== 7'b1111110 || fd4 !== (r % 16 == 15)) begin
            bad++;
            $display("FAIL first_frame r=%0d: display=%b sel=%b fd=%b required %b %b %b",
                     r, disp4, sel4, fd4, 7'b1111110, es, r % 16 == 15);
         end
      end
   endtask

   task automatic test_tear;
      logic [6:0] exp_new [4] = '{7'b0111101, 7'b1001110, 7'b0011111, 7'b1110111};
      logic [6:0] ed;
      logic [3:0] es;
      for (int r = 0; r < 32; r++) begin
         load4 = (r == 5 || r == 13);
         val4  = r == 5 ? 16'h1234 : r == 13 ? 16'hABCD : 16'h0000;
         @(negedge clk);
         es = 4'b1 << ((r / 4) % 4);
         ed = r < 16 ? 7'b1111110 : exp_new[(r / 4) % 4];
         total++;
         if (sel4 !== es || disp4 !== ed || fd4 !== (r % 16 == 15)) begin
            bad++;
            $display("FAIL tear r=%0d: display=%b sel=%b fd=%b required %b %b %b",
                     r, disp4, sel4, fd4, ed, es, r % 16 == 15);
         end
      end
      load4 = 1'b0;
   endtask

   task automatic test_lz;
      logic [6:0] exp_f [3][4] = '{'{7'b0111101, 7'b1001110, 7'b0011111, 7'b1110111},
                                   '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000},
                                   '{7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000}};
      logic [6:0] ed;
      logic [3:0] es;
      lz4 = 1'b1;
      for (int r = 0; r < 48; r++) begin
         load4 = (r == 2 || r == 20);
         val4  = r == 2 ? 16'h0050 : 16'h0000;
         @(negedge clk);
         es = 4'b1 << ((r / 4) % 4);
         ed = exp_f[r / 16][(r / 4) % 4];
         total++;
         if (sel4 !== es || disp4 !== ed || fd4 !== (r % 16 == 15)) begin
            bad++;
            $display("FAIL lz r=%0d: display=%b sel=%b fd=%b required %b %b %b",
                     r, disp4, sel4, fd4, ed, es, r % 16 == 15);
         end
      end
      load4 = 1'b0;
   endtask

   task automatic test_enable;
      logic [3:0] es;
      int         r;
      lz4 = 1'b0;
      for (int c = 0; c < 26; c++) begin
         en4 = !(c >= 10 && c < 20);
         @(negedge clk);
         total++;
         if (c >= 10 && c < 20) begin
            if (disp4 !== 7'b0 || sel4 !== 4'b0 || fd4 !== 1'b0) begin
               bad++;
               $display("FAIL enable_off c=%0d: display=%b sel=%b fd=%b required all 0", c, disp4, sel4, fd4);
            end
         end else begin
            r  = c < 10 ? c : c - 10;
            es = 4'b1 << (r / 4);
            if (sel4 !== es || disp4 !== 7'b1111110 || fd4 !== (r == 15)) begin
               bad++;
               $display("FAIL enable_on c=%0d: display=%b sel=%b fd=%b required %b %b %b",
                        c, disp4, sel4, fd4, 7'b1111110, es, r == 15);
            end
         end
      end
   endtask

   task automatic test_async_reset;
      logic [3:0] es;
      for (int r = 0; r < 6; r++) begin
         load4 = (r == 1);
         val4  = 16'hFFFF;
         @(negedge clk);
      end
      load4 = 1'b0;
      @(posedge clk);
      #3;
      rst4 = 1'b1;
      #1;
      total++;
      if (disp4 !== 7'b0 || sel4 !== 4'b0 || fd4 !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: display=%b sel=%b fd=%b required all 0", disp4, sel4, fd4);
      end
      @(negedge clk);
      rst4 = 1'b0;
      for (int r = 0; r < 32; r++) begin
         @(negedge clk);
         es = 4'b1 << ((r / 4) % 4);
         total++;
         if (sel4 !== es || disp4 !== 7'b1111110 || fd4 !== (r % 16 == 15)) begin
            bad++;
            $display("FAIL after_reset r=%0d: display=%b sel=%b fd=%b required %b %b %b",
                     r, disp4, sel4, fd4, 7'b1111110, es, r % 16 == 15);
         end
      end
   endtask

   task automatic test_sweep;
      int v;
      en1 = 1'b1;
      @(negedge clk);
      total++;
      if (disp1 !== 7'b0 || sel1 !== 1'b0 || fd1 !== 1'b0) begin
         bad++;
         $display("FAIL sweep_reset: display=%b sel=%b fd=%b required all 0", disp1, sel1, fd1);
      end
      rst1 = 1'b0;
      for (int p = 0; p < 38; p++) begin
         load1 = (p % 2 == 1 && p <= 31) || p == 34;
         val1  = p == 34 ? 4'h5 : 4'((p - 1) / 2);
         @(negedge clk);
         v = p < 2 ? 0 : p < 34 ? (p - 2) / 2 : p < 36 ? 15 : 5;
         total++;
         if (disp1 !== enc_tab[v] || sel1 !== 1'b1 || fd1 !== (p % 2 == 1)) begin
            bad++;
            $display("FAIL sweep p=%0d: display=%b sel=%b fd=%b required %b 1 %b",
                     p, disp1, sel1, fd1, enc_tab[v], p % 2 == 1);
         end
      end
      load1 = 1'b0;
   endtask

   initial begin
      rst4 = 1'b1; load4 = 1'b0; en4 = 1'b1; lz4 = 1'b0; val4 = '0;
      rst1 = 1'b1; load1 = 1'b0; en1 = 1'b1; lz1 = 1'b0; val1 = '0;
      test_reset();
      test_tear();
      test_lz();
      test_enable();
      test_async_reset();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
